// File: rtl/intr_timer.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer with prescaler, and a
// synchronized, edge-detected external request latched as pending until software clears it.
module intr_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        ext_src,
  output logic        timer_intr,
  output logic        ext_intr
);

  localparam int unsigned     CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADDR_EXT_PENDING = 3'd4;
  localparam logic [2:0] ADDR_CTRL        = 3'd5;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             timer_intr_q, ext_intr_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             tick_s, edge_s, pend_clr_s;

  // Next-state for counter, register file, read data and pending flag.
  always_comb begin
    tick_s       = (cnt_q == CNT_MAX);
    cnt_d        = tick_s ? CNT_ZERO : (cnt_q + CNT_ONE);
    mtime_d      = tick_s ? (mtime_q + 64'd1) : mtime_q;
    cmp_d        = cmp_q;
    ctrl_d       = ctrl_q;
    shadow_d     = shadow_q;
    pend_clr_s   = 1'b0;
    resp_rdata_d = 32'd0;

    if (req_valid && req_we) begin
      // A software write to either mtime half overrides the increment and restarts the prescaler.
      case (req_addr)
        ADDR_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], req_wdata};
          cnt_d   = CNT_ZERO;
        end
        ADDR_MTIME_HI: begin
          mtime_d = {req_wdata, mtime_q[31:0]};
          cnt_d   = CNT_ZERO;
        end
        ADDR_MTIMECMP_LO: cmp_d      = {cmp_q[63:32], req_wdata};
        ADDR_MTIMECMP_HI: cmp_d      = {req_wdata, cmp_q[31:0]};
        ADDR_EXT_PENDING: pend_clr_s = req_wdata[0];
        ADDR_CTRL:        ctrl_d     = req_wdata[1:0];
        default:          cmp_d      = cmp_q;
      endcase
    end else if (req_valid) begin
      case (req_addr)
        ADDR_MTIME_LO: begin
          resp_rdata_d = mtime_q[31:0];
          shadow_d     = mtime_q[63:32];
        end
        ADDR_MTIME_HI:    resp_rdata_d = shadow_q;
        ADDR_MTIMECMP_LO: resp_rdata_d = cmp_q[31:0];
        ADDR_MTIMECMP_HI: resp_rdata_d = cmp_q[63:32];
        ADDR_EXT_PENDING: resp_rdata_d = {31'd0, pend_q};
        ADDR_CTRL:        resp_rdata_d = {30'd0, ctrl_q};
        default:          resp_rdata_d = 32'd0;
      endcase
    end else begin
      resp_rdata_d = 32'd0;
    end

    edge_s = sync2_q & ~sync3_q;
    if (edge_s) begin
      pend_d = 1'b1;
    end else if (pend_clr_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q      <= 64'd0;
      cmp_q        <= 64'hFFFF_FFFF_FFFF_FFFF;
      cnt_q        <= CNT_ZERO;
      ctrl_q       <= 2'b11;
      shadow_q     <= 32'd0;
      pend_q       <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      timer_intr_q <= 1'b0;
      ext_intr_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      mtime_q      <= mtime_d;
      cmp_q        <= cmp_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      sync1_q      <= ext_src;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      timer_intr_q <= ctrl_q[0] && (mtime_q >= cmp_q);
      ext_intr_q   <= pend_q && ctrl_q[1];
      resp_valid_q <= req_valid;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign timer_intr = timer_intr_q;
  assign ext_intr   = ext_intr_q;

endmodule

// File: tb/tb_intr_timer.sv
// Directed bench for intr_timer: one instance with PRESCALE=1 and one with PRESCALE=4
// share the stimulus; expected values are hand-computed per cycle.
module tb_intr_timer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_addr = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        ext_src = 1'b0;

  logic        resp_valid1, resp_valid4;
  logic [31:0] resp_rdata1, resp_rdata4;
  logic        timer_intr1, timer_intr4;
  logic        ext_intr1, ext_intr4;

  logic [31:0] d1, d4;
  logic [31:0] rst_exp [8];
  int          checks = 0;
  int          errors = 0;

  intr_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .ext_src(ext_src), .timer_intr(timer_intr1),
    .ext_intr(ext_intr1)
  );

  intr_timer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid4),
    .resp_rdata(resp_rdata4), .ext_src(ext_src), .timer_intr(timer_intr4),
    .ext_intr(ext_intr4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'd0;
    step();
    req_valid = 1'b0;
    chk("rd_resp_valid", resp_valid1, 1'b1);
    chk("rd_resp_valid4", resp_valid4, 1'b1);
    d1 = resp_rdata1;
    d4 = resp_rdata4;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = data;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_resp_valid", resp_valid1, 1'b1);
    chk("wr_resp_rdata", resp_rdata1, 32'd0);
  endtask

  task automatic chk_outs(input string tag, input logic t_exp, input logic e_exp);
    chk({tag, "_timer1"}, timer_intr1, t_exp);
    chk({tag, "_timer4"}, timer_intr4, t_exp);
    chk({tag, "_ext1"}, ext_intr1, e_exp);
    chk({tag, "_ext4"}, ext_intr4, e_exp);
  endtask

  initial begin
    rst_exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd0, 32'd0};

    // Reset and readback
    step();
    step();
    chk_outs("rst", 1'b0, 1'b0);
    chk("rst_resp_valid", resp_valid1, 1'b0);
    #4 rstn = 1'b1;
    step();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      if (a != 0) begin
        chk($sformatf("rst_read%0d", a), d1, rst_exp[a]);
        chk($sformatf("rst_read4_%0d", a), d4, rst_exp[a]);
      end
    end
    step();
    chk("idle_resp_valid", resp_valid1, 1'b0);
    chk_outs("post_rst", 1'b0, 1'b0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6);
    chk("addr6_ignored", d1, 32'd0);

    // Timer fire, PRESCALE=1
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    repeat (8) step();
    chk("timer_before", timer_intr1, 1'b0);
    step();
    chk("timer_fire", timer_intr1, 1'b1);
    wr(3'd2, 32'hFFFF_FFFF);
    step();
    chk("timer_clear", timer_intr1, 1'b0);

    // Wrap and shadow
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFE);
    rd(3'd0);
    chk("wrap_lo0", d1, 32'hFFFF_FFFE);
    rd(3'd1);
    chk("wrap_shadow0", d1, 32'd0);
    rd(3'd0);
    chk("wrap_lo1", d1, 32'd0);
    rd(3'd1);
    chk("wrap_shadow1", d1, 32'd1);

    // Write/increment collision
    wr(3'd0, 32'd5);
    rd(3'd0);
    chk("coll_lo_p1", d1, 32'd5);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'd7);
    rd(3'd0);
    chk("coll_nocarry_lo", d1, 32'hFFFF_FFFF);
    rd(3'd1);
    chk("coll_nocarry_hi", d1, 32'd7);
    wr(3'd0, 32'd0);
    repeat (3) step();
    wr(3'd0, 32'd5);
    repeat (3) step();
    rd(3'd0);
    chk("coll_p4_hold", d4, 32'd5);
    rd(3'd0);
    chk("coll_p4_inc", d4, 32'd6);

    // External pending: latency, clear, set-beats-clear, level hold
    ext_src = 1'b1;
    step();
    ext_src = 1'b0;
    step();
    step();
    chk("ext_lat3_1", ext_intr1, 1'b0);
    chk("ext_lat3_4", ext_intr4, 1'b0);
    step();
    chk("ext_lat4_1", ext_intr1, 1'b1);
    chk("ext_lat4_4", ext_intr4, 1'b1);
    wr(3'd4, 32'd1);
    step();
    chk("ext_cleared", ext_intr1, 1'b0);
    rd(3'd4);
    chk("pend_cleared", d1, 32'd0);
    ext_src = 1'b1;
    step();
    ext_src = 1'b0;
    step();
    wr(3'd4, 32'd1);
    step();
    chk("setwins_ext", ext_intr1, 1'b1);
    rd(3'd4);
    chk("setwins_pend", d1, 32'd1);
    wr(3'd4, 32'd1);
    ext_src = 1'b1;
    repeat (4) step();
    rd(3'd4);
    chk("level_pend_set", d1, 32'd1);
    wr(3'd4, 32'd1);
    repeat (3) step();
    rd(3'd4);
    chk("level_no_reset", d1, 32'd0);
    ext_src = 1'b0;

    // Enable masking
    wr(3'd5, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    ext_src = 1'b1;
    step();
    ext_src = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_outs($sformatf("mask%0d", i), 1'b0, 1'b0);
    end
    rd(3'd4);
    chk("mask_pend1", d1, 32'd1);
    chk("mask_pend4", d4, 32'd1);
    rd(3'd5);
    chk("mask_ctrl0", d1, 32'd0);
    wr(3'd5, 32'hFFFF_FFFF);
    step();
    chk_outs("unmask", 1'b1, 1'b1);
    rd(3'd5);
    chk("ctrl_bits", d1, 32'd3);

    // Async reset mid-request
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
    #2 rstn = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0);
    chk("async_rst_rvalid", resp_valid1, 1'b0);
    step();
    req_valid = 1'b0;
    #4 rstn = 1'b1;
    step();
    chk("drop_rvalid1", resp_valid1, 1'b0);
    chk("drop_rvalid4", resp_valid4, 1'b0);
    rd(3'd5);
    chk("rst2_ctrl", d1, 32'd3);
    rd(3'd2);
    chk("rst2_cmp_lo", d1, 32'hFFFF_FFFF);
    rd(3'd4);
    chk("rst2_pend", d1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_timer.md
Name: intr_timer

Overview:
Machine-level interrupt source block. It drives the core's timer_intr and ext_intr inputs.
- Timer side: a 64-bit mtime counter, a 64-bit mtimecmp compare register and a prescaler.
- External side: an asynchronous request input is synchronized, edge-detected and held pending until software clears it.
- Software access is through a small word-addressed register port with a fixed 1-cycle response.

Parameters:
PRESCALE, 1, clk cycles per mtime increment (must be >= 1)

Ports:
clk        input   1   clock
rstn       input   1   asynchronous active-low reset
req_valid  input   1   register access request, one-cycle pulse
req_we     input   1   1 = write, 0 = read
req_addr   input   3   word address of register
req_wdata  input   32  write data
resp_valid output  1   response strobe
resp_rdata output  32  read data (0 for writes)
ext_src    input   1   asynchronous external interrupt request
timer_intr output  1   to core timer_intr
ext_intr   output  1   to core ext_intr

Behaviour:
- Reset (rstn low, asynchronous, any time) sets:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescale count = 0
  - ctrl = 2'b11 (bit0 timer enable, bit1 ext enable)
  - shadow_hi = 0, pending = 0, sync flops = 0
  - all outputs 0
  - A request in flight is dropped, with no resp_valid after reset release.
- Register map (addr):
  - 0 MTIME_LO. A read also latches mtime[63:32] into shadow_hi.
  - 1 MTIME_HI. A read returns shadow_hi; a write sets mtime[63:32].
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 EXT_PENDING. Read returns {31'b0, pending}; writing bit0 = 1 clears pending.
  - 5 CTRL. Bits [1:0] are read/write; other bits read 0.
  - 6, 7 read 0; writes to them are ignored.
- Handshake:
  - One request per cycle, no backpressure.
  - resp_valid is high exactly in the cycle after each req_valid, for reads and writes alike.
  - resp_rdata holds the register value sampled in the request cycle, before any increment in that cycle.
- Prescaler and mtime:
  - The counter counts 0..PRESCALE-1.
  - When it wraps, mtime increments by 1, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFF -> 0, with carry into HI).
  - With PRESCALE = 1, mtime increments every cycle.
  - mtime counts regardless of ctrl.
- mtime write:
  - A write to addr 0 or 1 replaces that half and resets the prescale count to 0.
  - It takes precedence over a same-cycle increment. That increment is lost, and there is no carry into the other half.
- Timer interrupt:
  - Registered: timer_intr <= ctrl[0] && (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - It rises 1 cycle after the condition becomes true.
  - It stays level-high until mtimecmp is raised, mtime is rewritten below mtimecmp, or ctrl[0] is cleared.
- External interrupt path:
  - ext_src passes through a 2-FF synchronizer.
  - A rising edge on the synchronized signal sets pending.
  - If a set and a clear occur in the same cycle, set wins and pending stays 1.
  - pending is captured even when ctrl[1] = 0.
  - Registered: ext_intr <= pending && ctrl[1]. Latency from an ext_src rise to ext_intr is 4 cycles (2 sync, 1 edge/pending, 1 output).
  - A level held high does not re-set pending after a clear; a new rising edge is required.
- Writes are full-word: 32-bit registers take all of req_wdata; CTRL and EXT_PENDING use only the bits defined above.

Test Plan:
- Reset/readback: release rstn, read addrs 0..7 -> resp_valid 1 cycle after each; CTRL=3, MTIMECMP_LO/HI = FFFFFFFF, EXT_PENDING=0, addrs 6/7 = 0; timer_intr=ext_intr=0.
- Timer fire (PRESCALE=1):
  - Write MTIME_LO=0, MTIME_HI=0, MTIMECMP_HI=0, MTIMECMP_LO=10.
  - timer_intr rises the cycle after mtime reaches 10.
  - Then write MTIMECMP_LO=FFFFFFFF -> timer_intr is 0 within 2 cycles.
- Wrap and shadow:
  - Write MTIME_HI=0, MTIME_LO=FFFFFFFE.
  - Read LO then HI across the carry -> HI returns the value latched at the LO read (0); a subsequent LO/HI pair returns HI=1.
- Write/increment collision: write MTIME_LO=5 in a cycle where the prescaler wraps -> mtime reads 5 or 6 per the PRESCALE timing with no extra increment; with PRESCALE=4, the next increment occurs 4 cycles after the write.
- External pending:
  - Pulse ext_src high 1 cycle -> ext_intr=1 exactly 4 cycles later.
  - Write EXT_PENDING=1 -> ext_intr=0 on the 2nd cycle after the write request.
  - A new edge arriving in the same cycle as the clear -> pending remains 1.
- Enable masking and async reset:
  - Set CTRL=0, trigger ext edge and timer match -> both outputs stay 0 and EXT_PENDING reads 1.
  - Set CTRL=3 -> both outputs assert the next cycle.
  - Assert rstn low mid-request -> all outputs 0 immediately, with no resp_valid.
